// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of a dual-clock FIFO: synchronises the remote Gray read pointer,
// advances the binary/Gray write pointers and derives registered full/almost_full/free/overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 9,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  w_rst,
    input  logic                  w_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   gray_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wclk_en,
    output logic [ADDR_WIDTH:0]   binary_wptr,
    output logic [ADDR_WIDTH:0]   gray_wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_free,
    output logic                  overflow
);

    localparam int AW    = ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_V   = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_V   = PW'(AFULL_THRESH);
    localparam logic          AFULL_RST = (DEPTH <= AFULL_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] used_d;
    logic [PW-1:0] free_q, free_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          wr_accept;

    assign rsync = sync_q[SYNC_STAGES-1];
    assign rbin  = gray2bin(rsync);

    assign wr_accept = w_en & ~full_q;

    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, wr_accept};
        gray_d  = wptr_d ^ (wptr_d >> 1);
        // Full when the next write pointer has lapped the read pointer by exactly one wrap.
        full_d  = (gray_d == {~rsync[AW:AW-1], rsync[AW-2:0]});
        used_d  = wptr_d - rbin;
        free_d  = DEPTH_V - used_d;
        afull_d = (free_d <= AFULL_V);
        // Set dominates clear when both happen on the same edge.
        ovf_d   = (w_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            wptr_q  <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= AFULL_RST;
            free_q  <= DEPTH_V;
            ovf_q   <= 1'b0;
        end else begin
            sync_q[0] <= gray_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            wptr_q  <= wptr_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            free_q  <= free_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = wptr_q[AW-1:0];
    assign wclk_en     = wr_accept;
    assign binary_wptr = wptr_q;
    assign gray_wptr   = gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_free     = free_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=2 (depth 8).
module tb_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       w_rst;
    logic       w_en;
    logic       ovf_clr;
    logic [3:0] gray_rptr;
    logic [2:0] waddr;
    logic       wclk_en;
    logic [3:0] binary_wptr;
    logic [3:0] gray_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_free;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AFULL_THRESH(2)
    ) dut (
        .clk        (clk),
        .w_rst      (w_rst),
        .w_en       (w_en),
        .ovf_clr    (ovf_clr),
        .gray_rptr  (gray_rptr),
        .waddr      (waddr),
        .wclk_en    (wclk_en),
        .binary_wptr(binary_wptr),
        .gray_wptr  (gray_wptr),
        .full       (full),
        .almost_full(almost_full),
        .wr_free    (wr_free),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    typedef struct {
        logic       w_en;
        logic       ovf_clr;
        logic       wclk_en;   // expected before the edge
        logic [3:0] wptr;      // expected after the edge
        logic [3:0] gptr;
        logic       full;
        logic       afull;
        logic [3:0] free;
        logic       ovf;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [3:0] mw;
        logic [3:0] prev;
        logic       wrap_seen;

        // fill from empty with read pointer parked at 0, then overflow handling
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b0, 4'd7, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd2, 4'b0011, 1'b0, 1'b0, 4'd6, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd3, 4'b0010, 1'b0, 1'b0, 4'd5, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd5, 4'b0111, 1'b0, 1'b0, 4'd3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd6, 4'b0101, 1'b0, 1'b1, 4'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd7, 4'b0100, 1'b0, 1'b1, 4'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b0};

        w_rst = 1'b0; w_en = 1'b0; ovf_clr = 1'b0; gray_rptr = 4'b0000;
        tick();
        tick();
        chk("rst_wptr",  binary_wptr, 4'd0);
        chk("rst_gptr",  gray_wptr,   4'd0);
        chk("rst_full",  full,        1'b0);
        chk("rst_afull", almost_full, 1'b0);
        chk("rst_free",  wr_free,     4'd8);
        chk("rst_ovf",   overflow,    1'b0);
        chk("rst_waddr", waddr,       3'd0);
        w_rst = 1'b1;
        tick();

        mw = 4'd0;
        for (int i = 0; i < 12; i++) begin
            w_en = vecs[i].w_en;
            ovf_clr = vecs[i].ovf_clr;
            #1;
            chk($sformatf("v%0d_wclk_en", i), wclk_en, vecs[i].wclk_en);
            chk($sformatf("v%0d_waddr", i),   waddr,   mw[2:0]);
            tick();
            chk($sformatf("v%0d_wptr", i),  binary_wptr, vecs[i].wptr);
            chk($sformatf("v%0d_gptr", i),  gray_wptr,   vecs[i].gptr);
            chk($sformatf("v%0d_full", i),  full,        vecs[i].full);
            chk($sformatf("v%0d_afull", i), almost_full, vecs[i].afull);
            chk($sformatf("v%0d_free", i),  wr_free,     vecs[i].free);
            chk($sformatf("v%0d_ovf", i),   overflow,    vecs[i].ovf);
            mw = vecs[i].wptr;
        end

        // read pointer jumps to 2: full is released only after the synchroniser delay
        w_en = 1'b0; ovf_clr = 1'b0; gray_rptr = 4'b0011;
        tick();
        chk("rel_full_e1", full, 1'b1);
        tick();
        chk("rel_full_e2", full, 1'b1);
        tick();
        chk("rel_full_e3",  full,        1'b0);
        chk("rel_free_e3",  wr_free,     4'd2);
        chk("rel_afull_e3", almost_full, 1'b1);

        // refill to full, then async reset in the middle of a cycle
        w_en = 1'b1;
        tick();
        chk("refill_free", wr_free, 4'd1);
        tick();
        w_en = 1'b0;
        chk("refill_full", full, 1'b1);
        chk("refill_wptr", binary_wptr, 4'd10);
        #3;
        w_rst = 1'b0;
        #1;
        chk("arst_wptr",  binary_wptr, 4'd0);
        chk("arst_gptr",  gray_wptr,   4'd0);
        chk("arst_full",  full,        1'b0);
        chk("arst_afull", almost_full, 1'b0);
        chk("arst_free",  wr_free,     4'd8);
        chk("arst_ovf",   overflow,    1'b0);
        chk("arst_waddr", waddr,       3'd0);
        gray_rptr = 4'b0000;
        #2;
        w_rst = 1'b1;
        tick();
        w_en = 1'b1;
        #1;
        chk("post_waddr", waddr, 3'd0);
        chk("post_wclk",  wclk_en, 1'b1);
        tick();
        chk("post_wptr", binary_wptr, 4'd1);

        // streaming with the read pointer trailing one behind: wraps, never full
        mw = 4'd1;
        wrap_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            gray_rptr = b2g(mw - 4'd1);
            #1;
            chk($sformatf("s%0d_full", i),  full,  1'b0);
            chk($sformatf("s%0d_waddr", i), waddr, mw[2:0]);
            prev = mw;
            tick();
            mw = mw + 4'd1;
            chk($sformatf("s%0d_wptr", i), binary_wptr, mw);
            chk($sformatf("s%0d_gptr", i), gray_wptr,   b2g(mw));
            if (prev == 4'd15) begin
                wrap_seen = 1'b1;
                chk("wrap_gray_before", b2g(prev), 4'b1000);
                chk("wrap_wptr",  binary_wptr, 4'd0);
                chk("wrap_gray",  gray_wptr,   4'b0000);
                chk("wrap_waddr", waddr,       3'd0);
            end
        end
        w_en = 1'b0;
        chk("wrap_seen", wrap_seen, 1'b1);
        tick();
        chk("stream_end_full", full, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
